// File: rtl/scarv_soc_pkg.sv
// Shared types and constants for the SCARV SoC memory-interface arbiter.
package scarv_soc_pkg;

   // Master identifier carried in the owner queue (0 = CPU, 1 = DMA/debug).
   typedef logic master_id_t;

   localparam master_id_t SOC_MASTER_CPU = 1'b0;
   localparam master_id_t SOC_MASTER_DMA = 1'b1;

   // Default number of granted requests that may await a response.
   localparam int SOC_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/scarv_soc_memif_arb_fifo.sv
// In-order owner-id FIFO: remembers which master issued each in-flight
// downstream transaction so responses can be routed back.
module scarv_soc_memif_arb_fifo
   import scarv_soc_pkg::*;
#(
   parameter int DEPTH = SOC_MAX_OUTSTANDING,
   parameter int PTR_W = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  master_id_t push_id_i,
   input  logic       pop_i,
   output logic       full_o,
   output logic       empty_o,
   output master_id_t head_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Storage is sized to the pointer range so pointer indexing is exact;
   // only the first DEPTH entries are ever used.
   master_id_t       mem_q [2**PTR_W];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Next-state for pointers and occupancy; simultaneous push/pop keeps count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
   end

   // State registers and storage write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < 2**PTR_W; i++) mem_q[i] <= SOC_MASTER_CPU;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_ok) mem_q[wr_ptr_q] <= push_id_i;
      end
   end

endmodule

// File: rtl/scarv_soc_memif_arbiter.sv
// Two-master round-robin arbiter onto the single peripheral memory port.
// Valid/ready: a request moves on a cycle with req && gnt, a response on a
// cycle with recv && ack; the requester holds req and payload until gnt.
module scarv_soc_memif_arbiter
   import scarv_soc_pkg::*;
#(
   parameter int MAX_OUTSTANDING = SOC_MAX_OUTSTANDING,
   parameter int ID_W            = 2
) (
   input  logic        f_clk,
   input  logic        g_resetn,
   input  logic [1:0]  m_req,
   output logic [1:0]  m_gnt,
   input  logic [1:0]  m_wen,
   input  logic [7:0]  m_strb,
   input  logic [63:0] m_addr,
   input  logic [63:0] m_wdata,
   output logic [1:0]  m_recv,
   input  logic [1:0]  m_ack,
   output logic [1:0]  m_error,
   output logic [63:0] m_rdata,
   output logic        s_req,
   input  logic        s_gnt,
   output logic        s_wen,
   output logic [3:0]  s_strb,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic        s_recv,
   output logic        s_ack,
   input  logic        s_error,
   input  logic [31:0] s_rdata
);

   master_id_t sel;
   master_id_t sel_q, sel_d;
   master_id_t prio_q, prio_d;
   logic       lock_q, lock_d;
   logic       q_full, q_empty;
   master_id_t q_head;
   logic       req_xfer, rsp_valid, rsp_xfer;

   // Choose the master to forward; a stalled handshake keeps its master so
   // the downstream payload cannot change before s_gnt.
   always_comb begin
      sel = prio_q;
      if (lock_q) begin
         sel = sel_q;
      end else begin
         case (m_req)
            2'b01:   sel = SOC_MASTER_CPU;
            2'b10:   sel = SOC_MASTER_DMA;
            default: sel = prio_q;
         endcase
      end
   end

   // Request path: zero-latency mux from the selected master. Reset gates
   // the handshake outputs so they drop the instant g_resetn falls.
   always_comb begin
      s_req    = g_resetn && m_req[sel] && !q_full;
      req_xfer = s_req && s_gnt;
      m_gnt    = '0;
      m_gnt[sel] = req_xfer;
      s_wen    = m_wen[sel];
      s_strb   = sel ? m_strb[7:4]    : m_strb[3:0];
      s_addr   = sel ? m_addr[63:32]  : m_addr[31:0];
      s_wdata  = sel ? m_wdata[63:32] : m_wdata[31:0];
   end

   // Response path: route to the master at the head of the owner queue.
   always_comb begin
      rsp_valid = g_resetn && s_recv && !q_empty;
      s_ack     = g_resetn && !q_empty && m_ack[q_head];
      rsp_xfer  = rsp_valid && s_ack;
      m_recv    = '0;
      m_error   = '0;
      m_recv[q_head]  = rsp_valid;
      m_error[q_head] = s_error && !q_empty;
      m_rdata   = {s_rdata, s_rdata};
   end

   // Next-state for the priority pointer and the selection lock.
   always_comb begin
      prio_d = prio_q;
      if (req_xfer) prio_d = ~sel;
      lock_d = s_req && !s_gnt;
      sel_d  = sel;
   end

   // Arbitration state registers.
   always_ff @(posedge f_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         prio_q <= SOC_MASTER_CPU;
         lock_q <= 1'b0;
         sel_q  <= SOC_MASTER_CPU;
      end else begin
         prio_q <= prio_d;
         lock_q <= lock_d;
         sel_q  <= sel_d;
      end
   end

   scarv_soc_memif_arb_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .PTR_W (ID_W)
   ) u_owner_fifo (
      .clk_i     (f_clk),
      .rst_ni    (g_resetn),
      .push_i    (req_xfer),
      .push_id_i (sel),
      .pop_i     (rsp_xfer),
      .full_o    (q_full),
      .empty_o   (q_empty),
      .head_o    (q_head)
   );

   // A response with nothing outstanding is a peripheral protocol error.
   spurious_rsp_a : assert property (@(posedge f_clk) disable iff (!g_resetn)
      !(s_recv && q_empty))
      else $warning("memif arbiter: response received with empty owner queue");

endmodule

// File: doc/scarv_soc_memif_arbiter.md
Name: scarv_soc_memif_arbiter

Overview:
- Shares the single downstream memory interface into the peripheral sub-system between two masters: master 0 is the CPU core-complex external port and master 1 is a DMA/debug master.
- Uses round-robin arbitration on the request channel.
- Tracks the owner of each in-flight transaction in a small in-order queue, so each response is routed back to the master that issued it.

Parameters:
- MAX_OUTSTANDING, 2, maximum number of granted requests awaiting a response (1..4).
- ID_W, 2, width of the owner-queue pointers; must satisfy 2^ID_W >= MAX_OUTSTANDING.

Ports:
- f_clk  in  1  clock.
- g_resetn  in  1  reset, asynchronous assert, active low.
- m_req  in  2  request valid per master; bit i = master i.
- m_gnt  out  2  request accepted per master.
- m_wen  in  2  write enable per master.
- m_strb  in  8  byte strobes; [4i+3:4i] = master i.
- m_addr  in  64  address; [32i+31:32i] = master i.
- m_wdata  in  64  write data, same packing as m_addr.
- m_recv  out  2  response valid per master.
- m_ack  in  2  response accepted per master.
- m_error  out  2  response error per master.
- m_rdata  out  64  read data; identical value broadcast on both halves.
- s_req / s_gnt  out / in  1  downstream request handshake.
- s_wen, s_strb, s_addr, s_wdata  out  1/4/32/32  downstream request payload.
- s_recv / s_ack  in / out  1  downstream response handshake.
- s_error, s_rdata  in  1/32  downstream response payload.

Behaviour:
- Handshakes: a request transfers on a cycle where req && gnt; a response transfers on a cycle where recv && ack. A master holds req and payload stable until gnt.
- Reset values: m_gnt=0, m_recv=0, s_req=0, s_ack=0, queue empty, priority pointer prio=0 (master 0 preferred).
- Selection:
  - When no request is held, sel = the single requesting master; if both request, sel = prio.
  - The selection is locked in a register while s_req && !s_gnt, so the downstream payload never changes mid-handshake.
- Request forwarding:
  - s_req = m_req[sel] && !queue_full.
  - s_wen/strb/addr/wdata are muxed combinationally from the selected master.
  - m_gnt[sel] = s_gnt && s_req; the other bit of m_gnt is 0.
  - Zero added latency on the request path.
- Priority update: on each request transfer, prio <= ~sel (winner becomes lowest priority). prio is unchanged on cycles without a transfer.
- Owner queue:
  - FIFO of master ids, depth MAX_OUTSTANDING.
  - Push sel on each request transfer; pop on each response transfer.
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - Full: s_req is forced to 0 and no grant is issued; a pending m_req simply waits.
- Response routing:
  - m_recv[head] = s_recv && !queue_empty; s_ack = m_ack[head].
  - m_error[head] = s_error; the non-owner bits of m_recv and m_error are 0.
  - m_rdata = {s_rdata, s_rdata}.
- Spurious response: s_recv while the queue is empty → s_ack=0, no m_recv is raised, state is unchanged. A simulation-only assertion fires on this case.
- Same-cycle events: a response to one master and a grant to the other (or the same) master in one cycle are independent and both complete.
- Reset mid-operation: asserting g_resetn low immediately clears the queue, the lock and prio, and drops s_req and m_gnt. In-flight downstream transactions are abandoned; the peripheral side is reset alongside.
- Pointer arithmetic: ID_W-bit pointers plus an explicit count register wrap modulo MAX_OUTSTANDING. A non-power-of-2 depth wraps explicitly at MAX_OUTSTANDING-1.

Decomposition:
- Package scarv_soc_pkg holds:
  - typedef logic master_id_t (0=CPU, 1=DMA);
  - constants SOC_MASTER_CPU and SOC_MASTER_DMA;
  - default MAX_OUTSTANDING.
- One sub-module, scarv_soc_memif_arb_fifo: synchronous owner-id FIFO with push/pop/full/empty/head and asynchronous reset.

Test Plan:
- CPU only: m_req=01, addr 0x1000_0004, s_gnt=1 → s_addr=0x1000_0004, m_gnt=01 in the same cycle; then s_recv with s_rdata=0xDEADBEEF → m_recv=01, m_rdata[31:0]=0xDEADBEEF.
- Contention: m_req=11 held for 4 grants, s_gnt=1 every cycle, responses returned promptly → grant order CPU, DMA, CPU, DMA; the 4 responses route to owners in the same order.
- Stall lock: m_req=01, s_gnt=0 for 3 cycles, m_req[1] rises in cycle 2 → s_addr stays at the CPU address and the CPU is granted first.
- Queue full: MAX_OUTSTANDING=2, two grants with no response → s_req=0 and m_gnt=00 despite m_req=11; after one s_recv/s_ack, the next grant occurs on the following cycle.
- Error and spurious response: s_error=1 on a DMA-owned response → m_error=10; s_recv with an empty queue → s_ack=0, m_recv=00.
- Async reset: drop g_resetn with 2 outstanding requests → outputs 0 immediately; after release, a single CPU request is granted with prio=0.
